// File: rtl/keypad_pkg.sv
// Shared types, key map and pattern helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } scan_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot_idx_t;

    // Indexed by {row_idx, col_idx}; row 3 carries * as E and # as F.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic onehot_idx_t onehot_low_idx(input logic [3:0] pattern);
        onehot_idx_t res;
        res = '0;
        case (pattern)
            4'b1110: res = '{valid: 1'b1, idx: 2'd0};
            4'b1101: res = '{valid: 1'b1, idx: 2'd1};
            4'b1011: res = '{valid: 1'b1, idx: 2'd2};
            4'b0111: res = '{valid: 1'b1, idx: 2'd3};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module scan_tick_gen
    import keypad_pkg::*;
#(
    parameter int DIV = 27000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, debounce, key decode and one-cycle strobe.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DCW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : gBadParams
        $error("keypad_scanner: SCAN_DIV must be >= 4, DEBOUNCE_SCANS and REPEAT_SCANS >= 1");
    end

    logic [3:0]     colMeta_q;
    logic [3:0]     colSync_q;
    logic           tick;
    scan_state_e    state_q;
    logic [1:0]     rowIdx_q;
    logic [3:0]     row_q;
    logic [3:0]     colPat_q;
    logic [1:0]     colIdx_q;
    logic [DCW-1:0] dbCnt_q;
    logic [3:0]     keyCode_q;
    logic           keyValid_q;
    logic           keyHeld_q;

    onehot_idx_t    sample;
    logic [1:0]     rowIdx_d;
    logic           patMatch;
    logic [1:0]     acceptCol;
    logic [3:0]     keyCode_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int RCW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RCW-1:0] RPT_LAST = RCW'(REPEAT_SCANS);
    logic [RCW-1:0] rptCnt_q;
`endif

    scan_tick_gen #(
        .DIV(SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // col is asynchronous to clk; only the second stage feeds decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colMeta_q <= 4'b1111;
            colSync_q <= 4'b1111;
        end else begin
            colMeta_q <= col;
            colSync_q <= colMeta_q;
        end
    end

    assign sample    = onehot_low_idx(colSync_q);
    assign rowIdx_d  = rowIdx_q + 2'd1;
    assign patMatch  = (colSync_q == colPat_q);
    assign acceptCol = (state_q == SCAN) ? sample.idx : colIdx_q;
    assign keyCode_d = KEY_MAP[{rowIdx_q, acceptCol}];

    // dbCnt_q counts matching ticks in DEBOUNCE and non-matching ticks in HELD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            rowIdx_q   <= 2'd0;
            row_q      <= 4'b1110;
            colPat_q   <= 4'b1111;
            colIdx_q   <= 2'd0;
            dbCnt_q    <= '0;
            keyCode_q  <= 4'h0;
            keyValid_q <= 1'b0;
            keyHeld_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rptCnt_q   <= '0;
`endif
        end else begin
            keyValid_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    SCAN: begin
                        if (sample.valid) begin
                            colPat_q <= colSync_q;
                            colIdx_q <= sample.idx;
                            if (DEBOUNCE_SCANS <= 1) begin
                                keyCode_q  <= keyCode_d;
                                keyValid_q <= 1'b1;
                                keyHeld_q  <= 1'b1;
                                dbCnt_q    <= '0;
                                state_q    <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rptCnt_q   <= '0;
`endif
                            end else begin
                                dbCnt_q <= DCW'(1);
                                state_q <= DEBOUNCE;
                            end
                        end else begin
                            rowIdx_q <= rowIdx_d;
                            row_q    <= row_drive(rowIdx_d);
                        end
                    end
                    DEBOUNCE: begin
                        if (patMatch) begin
                            if (dbCnt_q + 1'b1 == DB_LAST) begin
                                keyCode_q  <= keyCode_d;
                                keyValid_q <= 1'b1;
                                keyHeld_q  <= 1'b1;
                                dbCnt_q    <= '0;
                                state_q    <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rptCnt_q   <= '0;
`endif
                            end else begin
                                dbCnt_q <= dbCnt_q + 1'b1;
                            end
                        end else begin
                            dbCnt_q  <= '0;
                            rowIdx_q <= rowIdx_d;
                            row_q    <= row_drive(rowIdx_d);
                            state_q  <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!patMatch) begin
                            if (dbCnt_q + 1'b1 == DB_LAST) begin
                                dbCnt_q   <= '0;
                                keyHeld_q <= 1'b0;
                                rowIdx_q  <= rowIdx_d;
                                row_q     <= row_drive(rowIdx_d);
                                state_q   <= SCAN;
                            end else begin
                                dbCnt_q <= dbCnt_q + 1'b1;
                            end
                        end else begin
                            dbCnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rptCnt_q + 1'b1 == RPT_LAST) begin
                                rptCnt_q   <= '0;
                                keyValid_q <= 1'b1;
                            end else begin
                                rptCnt_q <= rptCnt_q + 1'b1;
                            end
`endif
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign row       = row_q;
    assign key_code  = keyCode_q;
    assign key_valid = keyValid_q;
    assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated key matrix drives col from row,
// and a tick-level behavioural model is compared against the outputs every cycle.
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DB  = 2;
    localparam int RPT = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed  = '0;
    logic        forceEn  = 1'b0;
    logic [3:0]  forceCol = 4'hF;
    logic [3:0]  keypadCol;

    int totalChecks  = 0;
    int passedChecks = 0;

    keypad_scanner #(
        .SCAN_DIV      (DIV),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_SCANS  (RPT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col      (col),
        .row      (row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its column low only while its row is driven low.
    always_comb begin
        keypadCol = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r]) keypadCol[c] = 1'b0;
    end
    assign col = forceEn ? forceCol : keypadCol;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        totalChecks++;
        if (actual === expected) passedChecks++;
        else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    endtask

    // Behavioural model, stepped once per scan tick.
    string      keyChars = "123A456B789CE0FD";
    int         mDiv, mRowIdx, mRun, mMiss, mRpt;
    logic [3:0] mS1, mS2, mSample, mPat, mCode;
    bit         mValid, mHeld, mCand, mTick;

    function automatic logic [3:0] modelRow(input int idx);
        logic [3:0] r;
        r = 4'hF;
        r[idx] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] modelKeyCode(input int r, input logic [3:0] pat);
        int  c;
        byte ch;
        c = 0;
        for (int i = 0; i < 4; i++) if (!pat[i]) c = i;
        ch = keyChars.getc(r*4 + c);
        if (ch >= "A") return 4'(ch - "A" + 10);
        return 4'(ch - "0");
    endfunction

    function automatic bit singleLow(input logic [3:0] p);
        return $countones(~p) == 1;
    endfunction

    task automatic resetModel();
        mDiv = 0; mRowIdx = 0; mRun = 0; mMiss = 0; mRpt = 0;
        mS1 = 4'hF; mS2 = 4'hF; mPat = 4'hF; mCode = 4'h0;
        mValid = 0; mHeld = 0; mCand = 0;
    endtask

    task automatic modelAccept();
        mCand = 0; mHeld = 1; mValid = 1; mMiss = 0; mRpt = 0;
        mCode = modelKeyCode(mRowIdx, mPat);
    endtask

    task automatic modelTick(input logic [3:0] p);
        if (mHeld) begin
            if (p != mPat) begin
                mMiss++;
                if (mMiss >= DB) begin
                    mHeld = 0; mMiss = 0; mRowIdx = (mRowIdx + 1) % 4;
                end
            end else begin
                mMiss = 0;
`ifdef KEYPAD_REPEAT_EN
                mRpt++;
                if (mRpt % RPT == 0) mValid = 1;
`endif
            end
        end else if (mCand) begin
            if (p == mPat) begin
                mRun++;
                if (mRun >= DB) modelAccept();
            end else begin
                mCand = 0; mRowIdx = (mRowIdx + 1) % 4;
            end
        end else if (singleLow(p)) begin
            mPat = p; mRun = 1;
            if (mRun >= DB) modelAccept();
            else mCand = 1;
        end else begin
            mRowIdx = (mRowIdx + 1) % 4;
        end
    endtask

    initial begin
        resetModel();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                resetModel();
            end else begin
                mValid  = 0;
                mTick   = (mDiv == DIV - 1);
                mSample = mS2;
                mS2     = mS1;
                mS1     = col;
                mDiv    = mTick ? 0 : mDiv + 1;
                if (mTick) modelTick(mSample);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("rowCode", {row, key_code}, {modelRow(mRowIdx), mCode});
                checkOutput("validHeld", {6'd0, key_valid, key_held}, {6'd0, mValid, mHeld});
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] keys, input int cycles);
        pressed = keys;
        forceEn = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitCycles(input int n, output int strobes);
        strobes = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid) strobes++;
        end
    endtask

    task automatic waitStrobe(input string name, input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!key_valid && cycles < limit);
        checkOutput(name, {7'd0, key_valid}, 8'd1);
    endtask

    task automatic waitRow(input string name, input logic [3:0] target, input int limit);
        int n;
        n = 0;
        while (row !== target && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {4'd0, row}, {4'd0, target});
    endtask

    task automatic waitHeldLow(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (key_held && cycles < limit);
    endtask

    logic [3:0] idleSeq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    initial begin
        int s, cyc, sawValid, k, sel;
        logic [15:0] keys;

        repeat (3) @(negedge clk);
        checkOutput("resetRow", {4'd0, row}, 8'h0E);
        checkOutput("resetCode", {4'd0, key_code}, 8'h00);
        checkOutput("resetValidHeld", {6'd0, key_valid, key_held}, 8'h00);
        rst_n = 1'b1;

        sawValid = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (key_valid) sawValid++;
            if (n % 4 == 2) checkOutput("idleRow", {4'd0, row}, {4'd0, idleSeq[n/4]});
        end
        checkOutput("idleNoStrobe", 8'(sawValid), 8'd0);

        pressed = 16'h0040;
        waitStrobe("key6Strobe", 100, cyc);
        checkOutput("key6Code", {4'd0, key_code}, 8'h06);
        checkOutput("key6Held", {7'd0, key_held}, 8'd1);
        checkOutput("key6Row", {4'd0, row}, 8'h0D);
        @(negedge clk);
        checkOutput("key6Pulse", {7'd0, key_valid}, 8'd0);
        waitCycles(40, s);
`ifndef KEYPAD_REPEAT_EN
        checkOutput("key6NoRepeat", 8'(s), 8'd0);
`endif
        pressed = '0;
        waitHeldLow(40, cyc);
        checkOutput("key6Released", {7'd0, key_held}, 8'd0);

        pressed = 16'h8000;
        waitStrobe("keyDStrobe", 100, cyc);
        checkOutput("keyDCode", {4'd0, key_code}, 8'h0D);
        pressed = '0;
        waitHeldLow(40, cyc);
        checkOutput("keyDReleaseLatency", 8'((cyc >= 7 && cyc <= 10) ? 1 : 0), 8'd1);
        checkOutput("keyDResumeRow", {4'd0, row}, 8'h0E);

        forceCol = 4'b1110;
        forceEn  = 1'b1;
        waitCycles(4, s);
        sawValid = s;
        forceEn  = 1'b0;
        waitCycles(5, s);
        sawValid += s;
        checkOutput("glitchRow", {4'd0, row}, 8'h0D);
        waitCycles(8, s);
        sawValid += s;
        checkOutput("glitchNoStrobe", 8'(sawValid), 8'd0);
        checkOutput("glitchKeepsCode", {4'd0, key_code}, 8'h0D);

        forceCol = 4'b1100;
        forceEn  = 1'b1;
        waitCycles(24, s);
        forceEn  = 1'b0;
        checkOutput("twoKeyNoStrobe", 8'(s), 8'd0);
        checkOutput("twoKeyKeepsCode", {4'd0, key_code}, 8'h0D);

        waitRow("waitRow3", 4'b0111, 40);
        pressed = 16'h0001;
        waitRow("waitRow0", 4'b1110, 40);
        waitCycles(5, s);
        checkOutput("midDebounceNoStrobe", 8'(s), 8'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncResetRow", {4'd0, row}, 8'h0E);
        checkOutput("asyncResetCode", {4'd0, key_code}, 8'h00);
        checkOutput("asyncResetValidHeld", {6'd0, key_valid, key_held}, 8'h00);
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;

        pressed = 16'h2000;
        waitStrobe("key0Strobe", 100, cyc);
        checkOutput("key0Code", {4'd0, key_code}, 8'h00);
`ifdef KEYPAD_REPEAT_EN
        waitStrobe("key0Repeat", 40, cyc);
        checkOutput("key0RepeatGap", 8'(cyc), 8'd12);
        checkOutput("key0RepeatCode", {4'd0, key_code}, 8'h00);
        pressed = '0;
        waitHeldLow(40, cyc);
        waitCycles(30, s);
        checkOutput("key0NoRepeatAfterRelease", 8'(s), 8'd0);
`else
        waitCycles(40, s);
        checkOutput("key0SingleStrobe", 8'(s), 8'd0);
        pressed = '0;
        waitHeldLow(40, cyc);
`endif
        applyStimulus('0, 12);

        for (int it = 0; it < 80; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                keys = 16'h0001 << $urandom_range(0, 15);
                applyStimulus(keys, $urandom_range(4, 60));
                applyStimulus('0, $urandom_range(4, 40));
            end else if (sel == 6) begin
                keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                applyStimulus(keys, $urandom_range(8, 50));
                applyStimulus('0, $urandom_range(4, 30));
            end else if (sel == 7) begin
                forceCol = 4'($urandom_range(0, 15));
                forceEn  = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                applyStimulus('0, $urandom_range(4, 20));
            end else if (sel == 8) begin
                pressed = 16'h0001 << $urandom_range(0, 15);
                repeat ($urandom_range(2, 12)) @(negedge clk);
                #3 rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
                applyStimulus('0, $urandom_range(4, 20));
            end else begin
                keys = 16'h0001 << $urandom_range(0, 15);
                k = $urandom_range(2, 6);
                for (int b = 0; b < k; b++) begin
                    applyStimulus(keys, $urandom_range(1, 5));
                    applyStimulus('0, $urandom_range(1, 5));
                end
                applyStimulus(keys, $urandom_range(10, 40));
                applyStimulus('0, $urandom_range(10, 30));
            end
        end

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
